id_regfile_sb: RTL and testbench
================================

Name: id_regfile_sb

Overview:
- Register-file end of the WB→RF write-back bus: 32×32 GPR array in the decode stage.
- Accepts byte-lane writes from WB and provides two combinational read ports with same-cycle write bypass.
- Keeps a per-register in-flight scoreboard so decode can stall on RAW hazards.
- Issue events increment a register's count; WB writes decrement it; a flush clears all counts.

Parameters:
- SB_W, 2: width of each per-register in-flight counter; max outstanding writers = 2^SB_W − 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ws_to_rf_bus  in  `WS_TO_RF_BUS_WD (41)  {rf_we[40:37], rf_waddr[36:32], rf_wdata[31:0]} from WB; rf_we is already gated by WB valid
- raddr1  in  5  read port 1 address
- raddr2  in  5  read port 2 address
- rdata1  out  32  read port 1 data (bypassed)
- rdata2  out  32  read port 2 data (bypassed)
- rbusy1  out  1  raddr1 has an outstanding writer not satisfied this cycle
- rbusy2  out  1  raddr2 has an outstanding writer not satisfied this cycle
- issue_valid  in  1  decode issues an instruction that will write issue_dest
- issue_dest  in  5  destination of issuing instruction
- flush  in  1  pipeline flush (exception/eret); discards all in-flight records
- sb_err  out  1  sticky: counter overflow or underflow detected

Behaviour:
- Reset:
  - All counters cleared to 0; sb_err = 0.
  - GPR contents are not reset; r1–r31 are undefined until written.
- r0:
  - Reads always return 0 and rbusy is always 0.
  - Writes and issues to r0 are ignored; r0 has no counter.
- Write:
  - A commit is any cycle with rf_we != 0 and rf_waddr != 0.
  - At posedge clk, each byte lane i with rf_we[i] = 1 gets regs[rf_waddr][8i+7:8i] <= rf_wdata[8i+7:8i].
  - Lanes with rf_we[i] = 0 are unchanged. This supports partial (LWL/LWR) writes.
- Read:
  - Zero latency, combinational.
  - If raddr == rf_waddr, raddr != 0 and rf_we != 0: per lane, output rf_wdata when rf_we[i] = 1, else the stored byte.
  - Otherwise output the stored value.
- Scoreboard:
  - cnt[r] is SB_W bits, one per register r = 1..31.
  - inc = issue_valid && issue_dest == r.
  - dec = a commit to r (rf_we != 0 && rf_waddr == r).
  - Next state for r:
    - flush: 0. Flush wins over inc and dec in the same cycle; the commit's data still writes the array.
    - inc && dec: unchanged.
    - inc only: cnt+1. If cnt == all-ones, hold and set sb_err.
    - dec only: cnt−1. If cnt == 0, hold at 0 and set sb_err.
- Busy (read port k):
  - rbusy_k = (raddr_k != 0) && (cnt[raddr_k] > 1, or cnt[raddr_k] == 1 with no commit to raddr_k this cycle).
  - A single pending writer completing this cycle is satisfied via the bypass, so no stall.
  - Issue in the current cycle does not affect rbusy this cycle. Decode resolves same-cycle self-dependence.
- sb_err is cleared only by reset.
- Contract:
  - Decode pulses issue_valid exactly once per writing instruction, in the cycle it leaves decode.
  - Every such instruction later produces exactly one commit with nonzero rf_we, unless flushed.
  - Instructions that conditionally don't write (e.g. MOVN false) must not issue.

Decomposition:
- Shared package / mycpu.h:
  - `WS_TO_RF_BUS_WD (41) and the bus field offsets.
  - GPR count (32) and address width (5).
- Natural sub-module: rf_sb_cnt, a single-register saturating up/down counter with flush and error outputs, instantiated 31 times.
- Storage and bypass stay in the top level.

Test Plan:
- Full-word write then read: bus {4'hF, 5'd8, 32'hDEADBEEF} → same cycle rdata1 (raddr1 = 8) = DEADBEEF; after the edge, with bus idle, still DEADBEEF.
- Partial bypass: r9 = 32'h11223344; bus {4'b0011, 9, 32'hAABBCCDD} → same cycle rdata2 = 32'h1122CCDD; next cycle the stored value is 1122CCDD.
- r0 handling: bus {4'hF, 0, 32'hFFFFFFFF} and issue_dest = 0 → rdata = 0, rbusy = 0, no counter change, sb_err = 0.
- Scoreboard depth:
  - Issue r5 twice → rbusy1 = 1 (cnt = 2).
  - Commit r5 → rbusy1 still 1 in that cycle (cnt was 2); cnt = 1 afterwards.
  - Second commit → rbusy1 = 0 in that cycle with bypassed data; cnt = 0 afterwards.
- Simultaneous events and flush:
  - Issue and commit r7 in one cycle with cnt = 1 → cnt stays 1.
  - Flush with cnt[7] = 1 and a commit to r7 → cnt = 0; data written.
- Errors and reset:
  - Four issues to r3 with SB_W = 2 → sb_err = 1 and cnt holds at 3.
  - Separately, commit r4 with cnt = 0 → sb_err = 1.
  - Reset asserted mid-sequence → cnt all 0 and sb_err = 0 the next cycle.

Source files
------------

// File: rtl/id_regfile_sb_pkg.sv
// Shared definitions for the decode-stage register file: GPR geometry and
// the layout of the write-back bus coming from WB.
package id_regfile_sb_pkg;

    localparam int GPR_NUM         = 32;
    localparam int GPR_AW          = 5;
    localparam int WS_TO_RF_BUS_WD = 41;

    localparam int RF_WDATA_LSB = 0;
    localparam int RF_WADDR_LSB = 32;
    localparam int RF_WE_LSB    = 37;

    typedef struct packed {
        logic [3:0]        we;
        logic [GPR_AW-1:0] waddr;
        logic [31:0]       wdata;
    } ws_to_rf_t;

endpackage

// File: rtl/id_regfile_sb_cnt.sv
// One register's in-flight writer counter: saturating up/down with flush,
// flagging overflow/underflow attempts on err for the cycle they occur.
module id_regfile_sb_cnt #(
    parameter int SB_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            inc,
    input  logic            dec,
    output logic [SB_W-1:0] cnt,
    output logic            err
);

    logic [SB_W-1:0] cnt_nxt;

    // Flush discards every in-flight record, so it neither counts nor errors.
    always_comb begin
        cnt_nxt = cnt;
        err     = 1'b0;
        if (flush) begin
            cnt_nxt = '0;
        end else if (inc && !dec) begin
            if (&cnt) err = 1'b1;
            else      cnt_nxt = cnt + 1'b1;
        end else if (dec && !inc) begin
            if (cnt == '0) err = 1'b1;
            else           cnt_nxt = cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else       cnt <= cnt_nxt;
    end

endmodule

// File: rtl/id_regfile_sb.sv
// Decode-stage 32x32 GPR file with byte-lane write-back, same-cycle bypass on
// both read ports, and a per-register scoreboard for RAW stall detection.
module id_regfile_sb
    import id_regfile_sb_pkg::*;
#(
    parameter int SB_W = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
    input  logic [GPR_AW-1:0]          raddr1,
    input  logic [GPR_AW-1:0]          raddr2,
    output logic [31:0]                rdata1,
    output logic [31:0]                rdata2,
    output logic                       rbusy1,
    output logic                       rbusy2,
    input  logic                       issue_valid,
    input  logic [GPR_AW-1:0]          issue_dest,
    input  logic                       flush,
    output logic                       sb_err
);

    ws_to_rf_t         wb;
    logic              commit;
    logic [31:0]       regs [GPR_NUM];
    logic [SB_W-1:0]   cnt  [GPR_NUM];
    logic [GPR_NUM-1:1] cnt_err;

    assign wb     = ws_to_rf_t'(ws_to_rf_bus);
    assign commit = (|wb.we) && (wb.waddr != '0);

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (wb.we[i]) regs[wb.waddr][8*i +: 8] <= wb.wdata[8*i +: 8];
            end
        end
    end

    function automatic logic [31:0] bypass_read(input logic [GPR_AW-1:0] addr,
                                                input logic [31:0]       stored,
                                                input ws_to_rf_t         w);
        logic [31:0] v;
        v = stored;
        if (addr == '0) begin
            v = '0;
        end else if (addr == w.waddr && (|w.we)) begin
            for (int i = 0; i < 4; i++) begin
                if (w.we[i]) v[8*i +: 8] = w.wdata[8*i +: 8];
            end
        end
        return v;
    endfunction

    // A lone pending writer that commits this cycle is covered by the bypass.
    function automatic logic busy(input logic [GPR_AW-1:0] addr,
                                  input logic [SB_W-1:0]   c,
                                  input logic              cmt,
                                  input logic [GPR_AW-1:0] waddr);
        logic satisfied;
        satisfied = cmt && (waddr == addr);
        return (addr != '0) && ((c > 1) || (c == 1 && !satisfied));
    endfunction

    assign rdata1 = bypass_read(raddr1, regs[raddr1], wb);
    assign rdata2 = bypass_read(raddr2, regs[raddr2], wb);
    assign rbusy1 = busy(raddr1, cnt[raddr1], commit, wb.waddr);
    assign rbusy2 = busy(raddr2, cnt[raddr2], commit, wb.waddr);

    assign cnt[0] = '0;

    for (genvar r = 1; r < GPR_NUM; r++) begin : g_sb
        id_regfile_sb_cnt #(.SB_W(SB_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .flush (flush),
            .inc   (issue_valid && issue_dest == GPR_AW'(r)),
            .dec   (commit && wb.waddr == GPR_AW'(r)),
            .cnt   (cnt[r]),
            .err   (cnt_err[r])
        );
    end

    always_ff @(posedge clk) begin
        if (reset)         sb_err <= 1'b0;
        else if (|cnt_err) sb_err <= 1'b1;
    end

endmodule

// File: tb/tb_id_regfile_sb.sv
// Directed bench for id_regfile_sb: a spec-level model checked every cycle,
// plus literal expectations at the points of interest.
module tb_id_regfile_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [40:0] ws_to_rf_bus;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        rbusy1, rbusy2;
    logic        issue_valid;
    logic [4:0]  issue_dest;
    logic        flush;
    logic        sb_err;

    int checks = 0;
    int errors = 0;

    id_regfile_sb #(.SB_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .ws_to_rf_bus (ws_to_rf_bus),
        .raddr1       (raddr1),
        .raddr2       (raddr2),
        .rdata1       (rdata1),
        .rdata2       (rdata2),
        .rbusy1       (rbusy1),
        .rbusy2       (rbusy2),
        .issue_valid  (issue_valid),
        .issue_dest   (issue_dest),
        .flush        (flush),
        .sb_err       (sb_err)
    );

    always #5 clk = ~clk;

    // Reference model: pending writer counts, stored bytes and which bytes are known.
    int          m_cnt   [32];
    logic [31:0] m_regs  [32];
    logic [3:0]  m_known [32];
    logic        m_err     = 1'b0;
    logic        m_started = 1'b0;

    initial begin
        for (int r = 0; r < 32; r++) begin
            m_cnt[r]   = 0;
            m_regs[r]  = '0;
            m_known[r] = '0;
        end
    end

    always @(posedge clk) begin
        logic [3:0]  we;
        logic [4:0]  wa;
        logic [31:0] wd;
        {we, wa, wd} = ws_to_rf_bus;
        if (we != 0 && wa != 0) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    m_regs[wa][8*i +: 8] = wd[8*i +: 8];
                    m_known[wa][i] = 1'b1;
                end
            end
        end
        if (reset) begin
            m_started = 1'b1;
            m_err = 1'b0;
            for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        end else if (flush) begin
            for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                bit inc, dec;
                inc = issue_valid && issue_dest == r;
                dec = we != 0 && wa == r;
                if (inc && !dec) begin
                    if (m_cnt[r] == 3) m_err = 1'b1;
                    else m_cnt[r]++;
                end else if (dec && !inc) begin
                    if (m_cnt[r] == 0) m_err = 1'b1;
                    else m_cnt[r]--;
                end
            end
        end
    end

    task automatic model_read(input logic [4:0] a, output logic [31:0] v,
                              output logic [31:0] mask, output logic bsy);
        logic [3:0]  we;
        logic [4:0]  wa;
        logic [31:0] wd;
        bit          hit;
        {we, wa, wd} = ws_to_rf_bus;
        hit  = (a != 0) && (a == wa) && (we != 0);
        v    = '0;
        mask = '1;
        if (a != 0) begin
            for (int i = 0; i < 4; i++) begin
                if (hit && we[i]) begin
                    v[8*i +: 8] = wd[8*i +: 8];
                end else begin
                    v[8*i +: 8]    = m_regs[a][8*i +: 8];
                    mask[8*i +: 8] = {8{m_known[a][i]}};
                end
            end
        end
        bsy = (a != 0) && (m_cnt[a] > 1 || (m_cnt[a] == 1 && !hit));
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] v, mask;
        logic        b;
        if (m_started) begin
            model_read(raddr1, v, mask, b);
            check("model_rdata1", rdata1 & mask, v & mask);
            check("model_rbusy1", {31'd0, rbusy1}, {31'd0, b});
            model_read(raddr2, v, mask, b);
            check("model_rdata2", rdata2 & mask, v & mask);
            check("model_rbusy2", {31'd0, rbusy2}, {31'd0, b});
            check("model_sb_err", {31'd0, sb_err}, {31'd0, m_err});
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        ws_to_rf_bus = '0;
        issue_valid  = 1'b0;
        issue_dest   = '0;
        flush        = 1'b0;
    endtask

    task automatic wr(input logic [3:0] we, input logic [4:0] wa, input logic [31:0] wd);
        ws_to_rf_bus = {we, wa, wd};
    endtask

    task automatic iss(input logic [4:0] d);
        issue_valid = 1'b1;
        issue_dest  = d;
    endtask

    initial begin
        reset = 1'b1;
        ws_to_rf_bus = '0;
        raddr1 = '0;
        raddr2 = '0;
        issue_valid = 1'b0;
        issue_dest = '0;
        flush = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        raddr1 = 5'd5;
        #2;
        check("reset_sb_err", {31'd0, sb_err}, 32'd0);
        check("reset_rbusy1", {31'd0, rbusy1}, 32'd0);

        // Full-word write and bypass
        next_cycle(); iss(5'd8);
        next_cycle(); wr(4'hF, 5'd8, 32'hDEADBEEF); raddr1 = 5'd8;
        #2; check("full_bypass", rdata1, 32'hDEADBEEF);
        next_cycle();
        #2; check("full_stored", rdata1, 32'hDEADBEEF);

        // Partial write bypass
        next_cycle(); iss(5'd9);
        next_cycle(); iss(5'd9); wr(4'hF, 5'd9, 32'h11223344);
        next_cycle(); wr(4'b0011, 5'd9, 32'hAABBCCDD); raddr2 = 5'd9;
        #2; check("partial_bypass", rdata2, 32'h1122CCDD);
        next_cycle();
        #2; check("partial_stored", rdata2, 32'h1122CCDD);

        // r0 is hardwired
        next_cycle(); wr(4'hF, 5'd0, 32'hFFFFFFFF); iss(5'd0); raddr1 = 5'd0; raddr2 = 5'd0;
        #2; check("r0_rdata1", rdata1, 32'd0);
        check("r0_rbusy1", {31'd0, rbusy1}, 32'd0);
        next_cycle();
        #2; check("r0_sb_err", {31'd0, sb_err}, 32'd0);

        // Two outstanding writers on r5
        next_cycle(); iss(5'd5); raddr1 = 5'd5;
        next_cycle(); iss(5'd5);
        next_cycle();
        #2; check("r5_cnt2_busy", {31'd0, rbusy1}, 32'd1);
        next_cycle(); wr(4'hF, 5'd5, 32'h00000055);
        #2; check("r5_first_commit_busy", {31'd0, rbusy1}, 32'd1);
        next_cycle();
        #2; check("r5_cnt1_busy", {31'd0, rbusy1}, 32'd1);
        next_cycle(); wr(4'hF, 5'd5, 32'h12345678);
        #2; check("r5_last_commit_busy", {31'd0, rbusy1}, 32'd0);
        check("r5_last_commit_data", rdata1, 32'h12345678);
        next_cycle();
        #2; check("r5_cnt0_busy", {31'd0, rbusy1}, 32'd0);

        // Simultaneous issue/commit, then flush
        next_cycle(); iss(5'd7); raddr1 = 5'd7;
        next_cycle(); iss(5'd7); wr(4'hF, 5'd7, 32'h01010101);
        #2; check("r7_inc_dec_busy", {31'd0, rbusy1}, 32'd0);
        next_cycle();
        #2; check("r7_cnt_held", {31'd0, rbusy1}, 32'd1);
        next_cycle(); flush = 1'b1; wr(4'hF, 5'd7, 32'h77777777);
        next_cycle();
        #2; check("r7_flush_busy", {31'd0, rbusy1}, 32'd0);
        check("r7_flush_data", rdata1, 32'h77777777);
        check("r7_flush_no_err", {31'd0, sb_err}, 32'd0);

        // Overflow on r3: count saturates at 3
        raddr1 = 5'd3;
        for (int k = 0; k < 3; k++) begin
            next_cycle(); iss(5'd3);
        end
        next_cycle();
        #2; check("r3_three_no_err", {31'd0, sb_err}, 32'd0);
        iss(5'd3);
        next_cycle();
        #2; check("r3_overflow_err", {31'd0, sb_err}, 32'd1);
        next_cycle(); wr(4'hF, 5'd3, 32'h33333333);
        next_cycle(); wr(4'hF, 5'd3, 32'h33333334);
        next_cycle();
        #2; check("r3_held_busy", {31'd0, rbusy1}, 32'd1);
        wr(4'hF, 5'd3, 32'h33333335);
        #1; check("r3_final_commit", rdata1, 32'h33333335);

        // Reset clears sticky error and counts
        next_cycle(); iss(5'd10); raddr2 = 5'd10;
        next_cycle(); iss(5'd10);
        next_cycle(); reset = 1'b1;
        next_cycle(); reset = 1'b0;
        #2; check("reset_mid_err", {31'd0, sb_err}, 32'd0);
        check("reset_mid_busy", {31'd0, rbusy2}, 32'd0);

        // Underflow on r4
        next_cycle(); wr(4'hF, 5'd4, 32'h44444444);
        next_cycle();
        #2; check("r4_underflow_err", {31'd0, sb_err}, 32'd1);
        next_cycle(); reset = 1'b1;
        next_cycle(); reset = 1'b0;
        #2; check("final_reset_err", {31'd0, sb_err}, 32'd0);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
